vec_reg_bank: RTL and testbench

//   Multi-lane register bank: TOTAL_REGS vector registers, each LANES x WIDTH bits.
//   Two combinational read ports, one lane-masked synchronous write port, optional

---
 rtl/vec_reg_bank_if.sv | 27 ++
 rtl/vec_reg_bank.sv | 93 +++++++++
 tb/tb_vec_reg_bank.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/vec_reg_bank_if.sv
// Register bank access bus: the pipeline drives address/write/clear controls, the bank returns read data and READY.
// Parameters must match the vec_reg_bank instance that the bus connects to.
interface vec_reg_bank_if #(
    parameter int WIDTH = 32,
    parameter int LANES = 4
);
    logic                     CLR;
    logic                     WE3;
    logic [LANES-1:0]         WM3;
    logic [4:0]               RA1;
    logic [4:0]               RA2;
    logic [4:0]               RA3;
    logic [LANES*WIDTH-1:0]   WD3;
    logic [LANES*WIDTH-1:0]   RD1;
    logic [LANES*WIDTH-1:0]   RD2;
    logic                     READY;

    modport master (
        output CLR, WE3, WM3, RA1, RA2, RA3, WD3,
        input  RD1, RD2, READY
    );

    modport slave (
        input  CLR, WE3, WM3, RA1, RA2, RA3, WD3,
        output RD1, RD2, READY
    );
endinterface

// File: rtl/vec_reg_bank.sv
// Multi-lane vector register bank: 2 combinational read ports, 1 lane-masked write port, clear engine.
// Reads are zero-latency; writes land on the next edge; READY=0 while clearing drops all writes.
module vec_reg_bank #(
    parameter int WIDTH      = 32,
    parameter int LANES      = 4,
    parameter int TOTAL_REGS = 25,
    parameter int ZERO_REG   = 0,
    parameter int BYPASS     = 1
) (
    input  logic            CLK,
    input  logic            RST_N,
    vec_reg_bank_if.slave   bus
);
    localparam int DW = LANES * WIDTH;

    typedef enum logic {IDLE, CLEARING} state_t;

    state_t         r_state;
    logic [4:0]     r_idx;
    logic           r_ready;
    logic [DW-1:0]  r_mem [TOTAL_REGS];

    logic           w_ra3_ok;
    logic           w_wr_vld;
    logic [4:0]     w_ra [2];
    logic [DW-1:0]  w_rd [2];

    assign w_ra3_ok = ({1'b0, bus.RA3} < 6'(TOTAL_REGS)) &&
                      !((ZERO_REG != 0) && (bus.RA3 == 5'd0));
    assign w_wr_vld = r_ready && bus.WE3 && w_ra3_ok;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state <= CLEARING;
            r_idx   <= '0;
            r_ready <= 1'b0;
        end else begin
            case (r_state)
                CLEARING: begin
                    r_idx <= r_idx + 5'd1;
                    if ({1'b0, r_idx} == 6'(TOTAL_REGS - 1)) begin
                        r_state <= IDLE;
                        r_ready <= 1'b1;
                    end
                end
                default: begin
                    if (bus.CLR) begin
                        r_state <= CLEARING;
                        r_idx   <= '0;
                        r_ready <= 1'b0;
                    end
                end
            endcase
        end
    end

    // Storage has no reset: contents only become visible after the clear sweep.
    always_ff @(posedge CLK) begin
        if (r_state == CLEARING) begin
            r_mem[r_idx] <= '0;
        end else if (w_wr_vld) begin
            for (int l = 0; l < LANES; l++) begin
                if (bus.WM3[l]) begin
                    r_mem[bus.RA3][l*WIDTH +: WIDTH] <= bus.WD3[l*WIDTH +: WIDTH];
                end
            end
        end
    end

    assign w_ra[0] = bus.RA1;
    assign w_ra[1] = bus.RA2;

    always_comb begin
        for (int p = 0; p < 2; p++) begin
            w_rd[p] = '0;
            if (r_ready && ({1'b0, w_ra[p]} < 6'(TOTAL_REGS)) &&
                !((ZERO_REG != 0) && (w_ra[p] == 5'd0))) begin
                w_rd[p] = r_mem[w_ra[p]];
                if ((BYPASS != 0) && w_wr_vld && (bus.RA3 == w_ra[p])) begin
                    for (int l = 0; l < LANES; l++) begin
                        if (bus.WM3[l]) begin
                            w_rd[p][l*WIDTH +: WIDTH] = bus.WD3[l*WIDTH +: WIDTH];
                        end
                    end
                end
            end
        end
    end

    assign bus.RD1   = w_rd[0];
    assign bus.RD2   = w_rd[1];
    assign bus.READY = r_ready;
endmodule

// File: tb/tb_vec_reg_bank.sv
// Directed and random stimulus for vec_reg_bank (ZERO_REG=1, BYPASS=1) against an array-based reference model.
module tb_vec_reg_bank;
    localparam int W  = 32;
    localparam int L  = 4;
    localparam int NR = 25;

    logic CLK;
    logic RST_N;
    vec_reg_bank_if #(.WIDTH(W), .LANES(L)) bus ();

    vec_reg_bank #(.WIDTH(W), .LANES(L), .TOTAL_REGS(NR), .ZERO_REG(1), .BYPASS(1)) u_dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Reference model: register contents plus edges left before the bank is usable.
    logic [W-1:0] mreg [NR][L];
    int busy;
    int n_chk;
    int n_pass;

    function automatic logic [L*W-1:0] pk(input int a, input int b, input int c, input int d);
        logic [L*W-1:0] v;
        v = {d[W-1:0], c[W-1:0], b[W-1:0], a[W-1:0]};
        return v;
    endfunction

    function automatic logic m_wr_valid();
        return (busy == 0) && bus.WE3 && (int'(bus.RA3) < NR) && (bus.RA3 != 5'd0);
    endfunction

    function automatic logic [L*W-1:0] m_rd(input logic [4:0] ra);
        logic [L*W-1:0] r;
        r = '0;
        if (busy == 0 && int'(ra) < NR && ra != 5'd0) begin
            for (int l = 0; l < L; l++) r[l*W +: W] = mreg[ra][l];
            if (m_wr_valid() && bus.RA3 == ra)
                for (int l = 0; l < L; l++)
                    if (bus.WM3[l]) r[l*W +: W] = bus.WD3[l*W +: W];
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [L*W-1:0] obs, input logic [L*W-1:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic drive(input logic clr, input logic we, input logic [L-1:0] wm,
                         input logic [4:0] ra3, input logic [L*W-1:0] wd,
                         input logic [4:0] ra1, input logic [4:0] ra2);
        bus.CLR = clr; bus.WE3 = we; bus.WM3 = wm; bus.RA3 = ra3;
        bus.WD3 = wd;  bus.RA1 = ra1; bus.RA2 = ra2;
    endtask

    // Settle, compare every output with the model, advance model and DUT by one edge.
    task automatic cyc();
        #1;
        if (!RST_N) busy = NR;
        chk("rd1", bus.RD1, m_rd(bus.RA1));
        chk("rd2", bus.RD2, m_rd(bus.RA2));
        chk("ready", {127'd0, bus.READY}, {127'd0, busy == 0});
        if (!RST_N) begin
            busy = NR;
        end else if (busy > 0) begin
            busy--;
        end else begin
            if (m_wr_valid())
                for (int l = 0; l < L; l++)
                    if (bus.WM3[l]) mreg[bus.RA3][l] = bus.WD3[l*W +: W];
            if (bus.CLR) begin
                for (int r = 0; r < NR; r++)
                    for (int l = 0; l < L; l++) mreg[r][l] = '0;
                busy = NR;
            end
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic count_until_ready(input string tag);
        int cnt;
        cnt = 0;
        for (int k = 0; k < 40 && !bus.READY; k++) begin
            drive(1'b0, 1'($urandom_range(0, 1)), 4'hF, 5'd3, {4{32'hBAD0_0000}},
                  5'($urandom_range(0, 31)), 5'd3);
            cyc();
            cnt++;
        end
        chk(tag, 128'(cnt), 128'(NR));
    endtask

    initial begin
        n_chk = 0; n_pass = 0; busy = NR;
        for (int r = 0; r < NR; r++) for (int l = 0; l < L; l++) mreg[r][l] = '0;
        drive(1'b0, 1'b0, '0, '0, '0, '0, '0);

        // 1: reset held two cycles, then 25-cycle clear sweep
        RST_N = 1'b0;
        @(posedge CLK); #1;
        cyc(); cyc();
        RST_N = 1'b1;
        count_until_ready("reset_clear_len");
        for (int n = 0; n < NR; n++) begin
            drive(1'b0, 1'b0, '0, '0, '0, 5'(n), 5'(NR - 1 - n));
            #1;
            chk("reset_zero", bus.RD1, '0);
            cyc();
        end

        // 2: fill all registers, sweep them back
        for (int n = 0; n < NR; n++) begin
            drive(1'b0, 1'b1, 4'hF, 5'(n), pk(n, n + 100, n + 200, n + 300), 5'd31, 5'd0);
            cyc();
        end
        for (int n = 0; n < NR; n += 2) begin
            drive(1'b0, 1'b0, '0, '0, '0, 5'(n), 5'(n + 1));
            #1;
            chk("fill_even", bus.RD1, (n == 0) ? '0 : pk(n, n + 100, n + 200, n + 300));
            if (n + 1 < NR) chk("fill_odd", bus.RD2, pk(n + 1, n + 101, n + 201, n + 301));
            cyc();
        end
        drive(1'b0, 1'b0, '0, '0, '0, 5'd27, 5'd25);
        #1;
        chk("oob_read", bus.RD1, '0);
        cyc();

        // 3: lane-masked write with same-cycle forwarding
        drive(1'b0, 1'b1, 4'hF, 5'd5, pk(1, 2, 3, 4), 5'd5, 5'd6);
        cyc();
        drive(1'b0, 1'b1, 4'b0101, 5'd5, pk(9, 9, 9, 9), 5'd5, 5'd5);
        #1;
        chk("mask_bypass", bus.RD1, pk(9, 2, 9, 4));
        cyc();
        drive(1'b0, 1'b0, '0, '0, '0, 5'd5, 5'd5);
        #1;
        chk("mask_stored", bus.RD2, pk(9, 2, 9, 4));
        cyc();

        // 4: register 0 is hardwired to zero
        drive(1'b0, 1'b1, 4'hF, 5'd0, {4{32'hDEAD}}, 5'd0, 5'd0);
        #1;
        chk("zero_bypass", bus.RD1, '0);
        cyc();
        drive(1'b0, 1'b0, '0, '0, '0, 5'd0, 5'd1);
        #1;
        chk("zero_stored", bus.RD1, '0);
        cyc();

        // 5: clear with a concurrent write; writes during clear are dropped
        drive(1'b1, 1'b1, 4'hF, 5'd3, pk(77, 78, 79, 80), 5'd3, 5'd4);
        #1;
        chk("clr_bypass", bus.RD1, pk(77, 78, 79, 80));
        cyc();
        chk("clr_ready_drop", {127'd0, bus.READY}, '0);
        count_until_ready("clr_len");
        for (int n = 0; n < NR; n++) begin
            drive(1'b0, 1'b0, '0, '0, '0, 5'(n), 5'd3);
            #1;
            chk("clr_zero", bus.RD1, '0);
            cyc();
        end

        // 6: reset pulse at clear index 10 restarts the sweep
        drive(1'b1, 1'b0, '0, '0, '0, 5'd1, 5'd2);
        cyc();
        drive(1'b0, 1'b0, '0, '0, '0, 5'd1, 5'd2);
        for (int k = 0; k < 10; k++) cyc();
        RST_N = 1'b0;
        cyc();
        RST_N = 1'b1;
        count_until_ready("rst_mid_clear_len");

        // Random traffic against the model
        for (int k = 0; k < 400; k++) begin
            drive(($urandom_range(0, 39) == 0), 1'($urandom_range(0, 1)), 4'($urandom),
                  5'($urandom_range(0, 31)), {$urandom, $urandom, $urandom, $urandom},
                  5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
            if ($urandom_range(0, 3) == 0) bus.RA1 = bus.RA3;
            cyc();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
